// File: rtl/seq_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, LSB chunk first.
// Ports: clk, rst_n, start, a, b, cin, sub -> sum, cout, ovf, busy, done.
// Macro SEQ_ADDER_OVF_EN enables the signed-overflow flag (ovf = 0 otherwise).
module seq_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [KW-1:0]    k;

  int               base;
  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK-1:0] s_c;
  logic             c_out;
  logic             last;

  always_comb begin
    base = int'(k) * CHUNK;
    a_c  = a_q[base +: CHUNK];
    b_c  = b_q[base +: CHUNK];
    {c_out, s_c} = {1'b0, a_c} + {1'b0, b_c}
                 + {{CHUNK{1'b0}}, carry};
    last = (k == KW'(NCHUNK - 1));
  end

`ifdef SEQ_ADDER_OVF_EN
  // carry into the MSB recovered from the MSB sum bit
  logic c_msb;
  assign c_msb = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ s_c[CHUNK-1];
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      k     <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SEQ_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            k     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum[base +: CHUNK] <= s_c;
          carry <= c_out;
          if (last) begin
            cout  <= c_out;
`ifdef SEQ_ADDER_OVF_EN
            ovf   <= c_msb ^ c_out;
`endif
            k     <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_adder.sv
// Directed bench for seq_adder (WIDTH=16, CHUNK=4).
// Ports exercised: all; expected results hand-computed.
module tb_seq_adder;

`ifdef SEQ_ADDER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_bad = 0;

  seq_adder #(
    .WIDTH(16),
    .CHUNK(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sub  (sub),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; operands are scrambled right after the
  // accepting edge to show they were latched.
  task automatic do_op(input string tag,
                       input logic [15:0] ta,
                       input logic [15:0] tb_,
                       input logic tcin,
                       input logic tsub,
                       input logic [15:0] es,
                       input logic ec,
                       input logic eo);
    int n;
    int bc;
    a = ta;
    b = tb_;
    cin = tcin;
    sub = tsub;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~ta;
    b = ~tb_;
    cin = ~tcin;
    sub = ~tsub;
    n = 0;
    bc = 0;
    while (!done && n < 20) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
    end
    chk({tag, ".busy"}, 32'(bc), 32'd4);
    chk({tag, ".done"}, {31'd0, done}, 32'd1);
    chk({tag, ".sum"}, {16'd0, sum}, {16'd0, es});
    chk({tag, ".cout"}, {31'd0, cout}, {31'd0, ec});
    chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eo & OVF_EN});
    @(negedge clk);
    chk({tag, ".pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int dn;
    int acc;
    int last_acc;
    int cyc;
    logic pbusy;
    logic [15:0] la;
    logic [15:0] lb;
    logic [15:0] exp_s;

    rst_n = 1'b0;
    start = 1'b0;
    a = 16'h0;
    b = 16'h0;
    cin = 1'b0;
    sub = 1'b0;
    #3;
    chk("rst.sum", {16'd0, sum}, 32'd0);
    chk("rst.cout", {31'd0, cout}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("sub57", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub75", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    do_op("povf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("novf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    do_op("cin", 16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
    do_op("subcin", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0);
    do_op("negneg", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // reset after two RUN cycles
    a = 16'hFFFF;
    b = 16'h0000;
    cin = 1'b0;
    sub = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst.sum", {16'd0, sum}, 32'd0);
    chk("arst.cout", {31'd0, cout}, 32'd0);
    chk("arst.ovf", {31'd0, ovf}, 32'd0);
    chk("arst.busy", {31'd0, busy}, 32'd0);
    chk("arst.done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("arst.nodone", 32'(dn), 32'd0);
    do_op("post", 16'h00F0, 16'h0F10, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    // start held high; only IDLE accepts
    sub = 1'b0;
    cin = 1'b0;
    start = 1'b1;
    pbusy = busy;
    dn = 0;
    acc = 0;
    last_acc = 0;
    exp_s = 16'h0;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      la = 16'h1357 * 16'(i + 1);
      lb = 16'hF0F1 ^ (16'h0101 * 16'(i));
      a = la;
      b = lb;
      @(negedge clk);
      cyc++;
      if (busy && !pbusy) begin
        exp_s = la + lb;
        if (acc > 0)
          chk("hold.gap", 32'(cyc - last_acc), 32'd6);
        last_acc = cyc;
        acc++;
      end
      if (done) begin
        dn++;
        chk("hold.sum", {16'd0, sum}, {16'd0, exp_s});
      end
      pbusy = busy;
    end
    start = 1'b0;
    chk("hold.dones", 32'(dn), 32'd3);
    repeat (8) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
